// File: rtl/tff_updown_counter.sv
// Modulo-N up/down counter built from a bank of T flip-flops.
// Supports synchronous load with clamping, count enable, direction, and binary or Gray output.
module tff_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_gray,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap
);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_badWidth
            $error("tff_updown_counter: WIDTH must be in 2..16");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_badModulus
            $error("tff_updown_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam int unsigned      MOD_U   = MODULUS;

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] w_cntNext;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_loadVal;
    logic             w_atMax;
    logic             w_atZero;
    logic             w_tc;

    assign w_atMax  = (r_cnt == MAX_CNT);
    assign w_atZero = (r_cnt == '0);

    // Out-of-range load values clamp to the top of the count range.
    assign w_loadVal = (32'(i_din) < MOD_U) ? i_din : MAX_CNT;

    always_comb begin
        w_cntNext = r_cnt;
        if (i_load) begin
            w_cntNext = w_loadVal;
        end else if (i_en) begin
            if (i_up) begin
                w_cntNext = w_atMax ? '0 : r_cnt + ONE;
            end else begin
                w_cntNext = w_atZero ? MAX_CNT : r_cnt - ONE;
            end
        end
    end

    assign w_t  = r_cnt ^ w_cntNext;
    assign w_tc = i_en & ~i_load & (i_up ? w_atMax : w_atZero);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= r_cnt ^ w_t;
            r_wrap <= w_tc;
        end
    end

    assign o_q    = i_gray ? (r_cnt ^ (r_cnt >> 1)) : r_cnt;
    assign o_tc   = w_tc;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed vector bench for tff_updown_counter: a modulo-16 and a modulo-10 instance
// share one stimulus bus; each vector names which instance it checks.
module tb_tff_updown_counter;

    typedef struct {
        bit         selB;
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] din;
        logic       gray;
        logic [3:0] expQ;
        logic       expTc;
        logic       expWrap;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       gray;
    logic [3:0] qA, qB;
    logic       tcA, tcB, wrapA, wrapB;

    int totalChecks = 0;
    int badChecks   = 0;
    vec_t vecs[$];

    tff_updown_counter #(.WIDTH(4), .MODULUS(16)) dutA (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_up(up), .i_load(load),
        .i_din(din), .i_gray(gray), .o_q(qA), .o_tc(tcA), .o_wrap(wrapA)
    );

    tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dutB (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_up(up), .i_load(load),
        .i_din(din), .i_gray(gray), .o_q(qB), .o_tc(tcB), .o_wrap(wrapB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(bit selB, logic rst, logic e, logic u, logic ld,
                                   logic [3:0] d, logic g, logic [3:0] q,
                                   logic tc, logic wr);
        vec_t v;
        v.selB = selB; v.rst = rst; v.en = e; v.up = u; v.load = ld;
        v.din = d; v.gray = g; v.expQ = q; v.expTc = tc; v.expWrap = wr;
        return v;
    endfunction

    task automatic addVec(bit selB, logic rst, logic e, logic u, logic ld,
                          logic [3:0] d, logic g, logic [3:0] q, logic tc, logic wr);
        vecs.push_back(mkVec(selB, rst, e, u, ld, d, g, q, tc, wr));
    endtask

    task automatic checkOutput(string name, int idx, logic [15:0] got, logic [15:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s vec=%0d got=%0h want=%0h", name, idx, got, want);
        end
    endtask

    // tc is checked against the inputs just before the edge; q and wrap just after it.
    task automatic applyStimulus(vec_t v, int idx);
        reset = v.rst; en = v.en; up = v.up; load = v.load; din = v.din; gray = v.gray;
        #1;
        checkOutput("tc", idx, 16'(v.selB ? tcB : tcA), 16'(v.expTc));
        @(posedge clk);
        #1;
        checkOutput("q", idx, 16'(v.selB ? qB : qA), 16'(v.expQ));
        checkOutput("wrap", idx, 16'(v.selB ? wrapB : wrapA), 16'(v.expWrap));
    endtask

    initial begin
        logic [3:0] prevQ;
        reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; din = '0; gray = 1'b0;

        // mod-16: reset then count up 20 times through the wrap
        addVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            addVec(0, 0, 1, 1, 0, 0, 0, 4'((k + 1) % 16), (k % 16) == 15, (k % 16) == 15);
        // priority: reset over load over en
        addVec(0, 1, 1, 1, 1, 7, 0, 0, 0, 0);
        addVec(0, 0, 1, 1, 1, 7, 0, 7, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0, 8, 0, 0);
        // hold at 15, then wrap up and immediately back down
        addVec(0, 0, 0, 1, 1, 15, 0, 15, 0, 0);
        for (int k = 0; k < 3; k++)
            addVec(0, 0, 0, 1, 0, 0, 0, 15, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        addVec(0, 0, 1, 0, 0, 0, 0, 15, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 15, 0, 0);
        // reset while tc is high suppresses the wrap pulse
        addVec(0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        addVec(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        // reset mid-count at 6, then resume
        for (int k = 2; k <= 6; k++)
            addVec(0, 0, 1, 1, 0, 0, 0, 4'(k), 0, 0);
        addVec(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0, 2, 0, 0);
        // gray across the wrap in both directions
        addVec(0, 0, 0, 1, 1, 15, 1, 4'b1000, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 1, 4'b0000, 1, 1);
        addVec(0, 0, 1, 1, 0, 0, 1, 4'b0001, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 1, 4'b0000, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 1, 4'b1000, 1, 1);
        // mod-10: load 2, count down through the wrap, then clamped loads
        addVec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 2, 0, 2, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 0, 9, 1, 1);
        addVec(1, 0, 1, 0, 0, 0, 0, 8, 0, 0);
        addVec(1, 0, 1, 0, 1, 12, 0, 9, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 9, 0, 0);
        addVec(1, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        addVec(1, 0, 0, 0, 1, 10, 0, 9, 0, 0);
        addVec(1, 0, 1, 1, 1, 15, 0, 9, 0, 0);
        addVec(1, 0, 1, 1, 0, 0, 1, 4'b0000, 1, 1);
        addVec(1, 0, 0, 0, 1, 9, 1, 4'b1101, 0, 0);
        addVec(1, 0, 0, 0, 1, 5, 1, 4'b0111, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 1, 4'b0110, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // gray -> binary switch at cnt=5 is visible without an edge
        applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 1000);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 1, 4'b0001, 0, 0), 1001);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 1, 4'b0011, 0, 0), 1002);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 1, 4'b0010, 0, 0), 1003);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 1, 4'b0110, 0, 0), 1004);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 1, 4'b0111, 0, 0), 1005);
        gray = 1'b0; en = 1'b0;
        #1;
        checkOutput("graySwitch", 1006, 16'(qA), 16'd5);
        applyStimulus(mkVec(0, 0, 1, 1, 0, 0, 0, 6, 0, 0), 1007);

        // full gray cycle: every step including the wrap flips exactly one bit
        applyStimulus(mkVec(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 2000);
        prevQ = qA;
        reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; gray = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            checkOutput("grayStep", 2001 + i, 16'($countones(qA ^ prevQ)), 16'd1);
            prevQ = qA;
        end
        checkOutput("grayWrapQ", 2017, 16'(qA), 16'd0);
        checkOutput("grayWrapPulse", 2018, 16'(wrapA), 16'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
